// File: rtl/opendap_apb_initiator_if.sv
// Command/response stream plus APB bus bundle for the APB initiator.
// master = the initiator itself, slave = command source, response sink and APB completer.
interface opendap_apb_initiator_if #(
  parameter int W_ADDR = 8,
  parameter int W_DATA = 32,
  parameter int W_WAIT = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [W_ADDR-1:0] cmd_addr;
  logic [W_DATA-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W_DATA-1:0] rsp_rdata;
  logic              rsp_err;
  logic [W_WAIT-1:0] rsp_wait;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [W_ADDR-1:0] paddr;
  logic [W_DATA-1:0] pwdata;
  logic [W_DATA-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_wait,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_wait,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/opendap_apb_initiator.sv
// APB initiator: one transfer at a time, accept at edge N -> SETUP N+1, ACCESS N+2, response from N+3.
// A held, unconsumed response blocks cmd_ready, so no new APB transfer starts until it is taken.
module opendap_apb_initiator #(
  parameter int W_ADDR = 8,
  parameter int W_DATA = 32,
  parameter int W_WAIT = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  opendap_apb_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [W_WAIT-1:0] wait_cnt;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [W_ADDR-1:0] paddr;
  logic [W_DATA-1:0] pwdata;
  logic              rsp_valid;
  logic [W_DATA-1:0] rsp_rdata;
  logic              rsp_err;
  logic [W_WAIT-1:0] rsp_wait;
  logic              cmd_ready;
  logic              accept;
  logic              consume;

  // rst_n gating keeps cmd_ready low for the whole reset, not just after the first edge.
  assign cmd_ready = rst_n && (state == IDLE) && (!rsp_valid || bus.rsp_ready);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign consume   = rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_wait  <= '0;
    end else begin
      if (consume) begin
        rsp_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            pwrite   <= bus.cmd_write;
            paddr    <= bus.cmd_addr;
            pwdata   <= bus.cmd_wdata;
            wait_cnt <= '0;
            psel     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : bus.prdata;
            rsp_err   <= bus.pslverr;
            rsp_wait  <= wait_cnt;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else if (wait_cnt != {W_WAIT{1'b1}}) begin
            // Saturate rather than wrap so very long stalls still read as "many".
            wait_cnt <= wait_cnt + W_WAIT'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.psel      = psel;
  assign bus.penable   = penable;
  assign bus.pwrite    = pwrite;
  assign bus.paddr     = paddr;
  assign bus.pwdata    = pwdata;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_wait  = rsp_wait;

endmodule

// File: tb/tb_opendap_apb_initiator.sv
// Directed plus randomized bench for the APB initiator; a second instance with a 2-bit wait counter covers saturation.
module tb_opendap_apb_initiator;
  localparam int W_ADDR   = 8;
  localparam int W_DATA   = 32;
  localparam int W_WAIT   = 8;
  localparam int W_WAIT_B = 2;
  localparam int MAXW     = (1 << W_WAIT) - 1;
  localparam int MAXW_B   = (1 << W_WAIT_B) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opendap_apb_initiator_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_WAIT(W_WAIT))   ia ();
  opendap_apb_initiator_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_WAIT(W_WAIT_B)) ib ();

  opendap_apb_initiator #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_WAIT(W_WAIT)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.master));
  opendap_apb_initiator #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_WAIT(W_WAIT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.master));

  typedef struct {
    logic [W_DATA-1:0] rdata;
    logic              err;
    logic [W_WAIT-1:0] wt;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t last_rsp;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer on instance A; the expected response comes from the transfer's own parameters.
  task automatic xfer_a(input logic wr, input logic [W_ADDR-1:0] addr, input logic [W_DATA-1:0] wd,
                        input int nwait, input logic [W_DATA-1:0] rd, input logic er);
    rsp_t e;
    rsp_t got;
    ia.cmd_valid = 1'b1; ia.cmd_write = wr; ia.cmd_addr = addr; ia.cmd_wdata = wd;
    ia.pready = 1'b0;
    #1;
    check("a_cmd_ready_idle", 64'(ia.cmd_ready), 64'(1));
    e.rdata = wr ? '0 : rd;
    e.err   = er;
    e.wt    = W_WAIT'((nwait > MAXW) ? MAXW : nwait);
    exp_q.push_back(e);
    tick();
    ia.cmd_valid = 1'b0; ia.cmd_write = ~wr;
    ia.cmd_addr = W_ADDR'($urandom); ia.cmd_wdata = $urandom;
    #1;
    check("a_setup_psel",    64'(ia.psel),      64'(1));
    check("a_setup_penable", 64'(ia.penable),   64'(0));
    check("a_setup_paddr",   64'(ia.paddr),     64'(addr));
    check("a_setup_pwrite",  64'(ia.pwrite),    64'(wr));
    check("a_setup_pwdata",  64'(ia.pwdata),    64'(wd));
    check("a_setup_rsp_vld", 64'(ia.rsp_valid), 64'(0));
    check("a_setup_cmd_rdy", 64'(ia.cmd_ready), 64'(0));
    tick();
    check("a_access_psel",    64'(ia.psel),    64'(1));
    check("a_access_penable", 64'(ia.penable), 64'(1));
    for (int i = 0; i < nwait; i++) begin
      ia.pready = 1'b0; ia.pslverr = 1'($urandom); ia.prdata = $urandom;
      tick();
      check("a_wait_penable", 64'(ia.penable), 64'(1));
      check("a_wait_paddr",   64'(ia.paddr),   64'(addr));
      check("a_wait_pwdata",  64'(ia.pwdata),  64'(wd));
      check("a_wait_pwrite",  64'(ia.pwrite),  64'(wr));
    end
    ia.pready = 1'b1; ia.prdata = rd; ia.pslverr = er;
    tick();
    ia.pready = 1'b0; ia.pslverr = 1'b0; ia.prdata = $urandom;
    got = exp_q.pop_front();
    last_rsp = got;
    check("a_done_psel",   64'(ia.psel),      64'(0));
    check("a_done_penable",64'(ia.penable),   64'(0));
    check("a_rsp_valid",   64'(ia.rsp_valid), 64'(1));
    check("a_rsp_rdata",   64'(ia.rsp_rdata), 64'(got.rdata));
    check("a_rsp_err",     64'(ia.rsp_err),   64'(got.err));
    check("a_rsp_wait",    64'(ia.rsp_wait),  64'(got.wt));
  endtask

  // Hold a response unconsumed with a command waiting; nothing may move.
  task automatic stall_a(input int k);
    ia.rsp_ready = 1'b0;
    ia.cmd_valid = 1'b1; ia.cmd_addr = W_ADDR'($urandom); ia.cmd_write = 1'($urandom);
    for (int i = 0; i < k; i++) begin
      #1;
      check("a_stall_cmd_ready", 64'(ia.cmd_ready), 64'(0));
      tick();
      check("a_stall_psel",      64'(ia.psel),      64'(0));
      check("a_stall_rsp_valid", 64'(ia.rsp_valid), 64'(1));
      check("a_stall_rsp_rdata", 64'(ia.rsp_rdata), 64'(last_rsp.rdata));
      check("a_stall_rsp_err",   64'(ia.rsp_err),   64'(last_rsp.err));
      check("a_stall_rsp_wait",  64'(ia.rsp_wait),  64'(last_rsp.wt));
    end
    ia.cmd_valid = 1'b0;
  endtask

  task automatic xfer_b(input int nwait);
    logic [W_DATA-1:0] rd;
    ib.cmd_valid = 1'b1; ib.cmd_write = 1'b0; ib.cmd_addr = W_ADDR'($urandom);
    ib.pready = 1'b0;
    #1;
    check("b_cmd_ready", 64'(ib.cmd_ready), 64'(1));
    tick();
    ib.cmd_valid = 1'b0;
    tick();
    repeat (nwait) tick();
    rd = $urandom;
    ib.pready = 1'b1; ib.prdata = rd;
    tick();
    ib.pready = 1'b0;
    check("b_rsp_valid", 64'(ib.rsp_valid), 64'(1));
    check("b_rsp_rdata", 64'(ib.rsp_rdata), 64'(rd));
    check("b_rsp_wait",  64'(ib.rsp_wait),  64'((nwait > MAXW_B) ? MAXW_B : nwait));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic              wr;
    logic              er;
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] wd;
    logic [W_DATA-1:0] rd;

    rst_n = 1'b1;
    ia.cmd_valid = 1'b1; ia.cmd_write = 1'b0; ia.cmd_addr = '0; ia.cmd_wdata = '0;
    ia.rsp_ready = 1'b0; ia.prdata = '0; ia.pready = 1'b0; ia.pslverr = 1'b0;
    ib.cmd_valid = 1'b0; ib.cmd_write = 1'b0; ib.cmd_addr = '0; ib.cmd_wdata = '0;
    ib.rsp_ready = 1'b1; ib.prdata = '0; ib.pready = 1'b0; ib.pslverr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(ia.cmd_ready), 64'(0));
    check("rst_psel",      64'(ia.psel),      64'(0));
    check("rst_penable",   64'(ia.penable),   64'(0));
    check("rst_pwrite",    64'(ia.pwrite),    64'(0));
    check("rst_paddr",     64'(ia.paddr),     64'(0));
    check("rst_pwdata",    64'(ia.pwdata),    64'(0));
    check("rst_rsp_valid", 64'(ia.rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(ia.rsp_rdata), 64'(0));
    check("rst_rsp_err",   64'(ia.rsp_err),   64'(0));
    check("rst_rsp_wait",  64'(ia.rsp_wait),  64'(0));
    repeat (2) tick();
    check("rst_held_psel", 64'(ia.psel), 64'(0));
    rst_n = 1'b1;
    ia.cmd_valid = 1'b0;
    ia.rsp_ready = 1'b1;
    tick();

    // Zero-wait read, then a write with three wait states.
    xfer_a(1'b0, 8'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    xfer_a(1'b1, 8'h24, 32'h12345678, 3, $urandom, 1'b0);

    // Error response does not leak into the next transfer.
    xfer_a(1'b0, 8'h30, 32'h0, 1, 32'hCAFEF00D, 1'b1);
    xfer_a(1'b0, 8'h34, 32'h0, 0, 32'h0BADBEEF, 1'b0);

    // Backpressure: held response blocks the next command until consumed.
    xfer_a(1'b1, 8'h40, 32'hA5A5A5A5, 2, $urandom, 1'b1);
    stall_a(4);
    ia.rsp_ready = 1'b1;
    xfer_a(1'b0, 8'h44, 32'h0, 0, 32'h11223344, 1'b0);

    // Long stall saturates the 8-bit counter.
    xfer_a(1'b0, 8'h50, 32'h0, 260, 32'h55AA55AA, 1'b0);

    // Two-bit counter: saturates at 3, exact below.
    xfer_b(7);
    xfer_b(2);
    xfer_b(3);
    tick();

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom); er = 1'($urandom); addr = W_ADDR'($urandom);
      wd = $urandom; rd = $urandom;
      xfer_a(wr, addr, wd, $urandom_range(0, 5), rd, er);
      if ($urandom_range(0, 3) == 0) begin
        stall_a($urandom_range(1, 3));
        ia.rsp_ready = 1'b1;
      end
    end

    // Reset with a response pending discards it.
    xfer_a(1'b0, 8'h60, 32'h0, 0, 32'h77777777, 1'b0);
    ia.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_pend_rsp_valid", 64'(ia.rsp_valid), 64'(0));
    check("rst_pend_rsp_rdata", 64'(ia.rsp_rdata), 64'(0));
    tick();
    rst_n = 1'b1;
    ia.rsp_ready = 1'b1;
    tick();

    // Reset in the middle of ACCESS drops psel/penable without a clock.
    ia.cmd_valid = 1'b1; ia.cmd_write = 1'b0; ia.cmd_addr = 8'h70; ia.pready = 1'b0;
    tick();
    ia.cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_access_penable", 64'(ia.penable), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_psel",      64'(ia.psel),      64'(0));
    check("mid_rst_penable",   64'(ia.penable),   64'(0));
    check("mid_rst_rsp_valid", 64'(ia.rsp_valid), 64'(0));
    check("mid_rst_cmd_ready", 64'(ia.cmd_ready), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    xfer_a(1'b0, 8'h74, 32'h0, 1, 32'h0F0F0F0F, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
